// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fetches a 16-byte block as eight 16-bit reads and streams the
// returned words into the data array, writing the tag when the 8th word lands.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [15:0]           fill_data
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            issue_q, recv_q;
    logic                  in_fill, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else if (state_q == IDLE) begin
            if (miss_detected) begin
                state_q <= FILL;
                base_q  <= miss_address & ~ADDR_WIDTH'(4'hF);
                issue_q <= '0;
                recv_q  <= '0;
            end
        end else begin
            if (!issue_q[3]) issue_q <= issue_q + 4'd1;
            if (memory_data_valid) recv_q <= recv_q + 4'd1;
            if (last) state_q <= IDLE;
        end
    end

    // Offsets stay within the low nibble, so base + offset never carries past bit 3.
    always_comb begin
        in_fill          = state_q == FILL;
        fsm_busy         = in_fill;
        mem_enable       = in_fill && !issue_q[3];
        mem_wr           = 1'b0;
        memory_address   = mem_enable ? base_q + ADDR_WIDTH'({issue_q, 1'b0}) : '0;
        write_data_array = in_fill && memory_data_valid;
        last             = write_data_array && recv_q == 4'd7;
        write_tag_array  = last;
        fill_addr        = write_data_array ? base_q + ADDR_WIDTH'({recv_q, 1'b0}) : '0;
        fill_data        = memory_data;
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: random misses, memory latencies, stalls and resets; a
// scoreboard of expected issues and fill writes is checked by a separate monitor.
module tb_cache_fill_fsm;
    logic        clk = 0, rst = 1, miss_detected = 0, memory_data_valid = 0;
    logic [15:0] miss_address = 0, memory_data = 0;
    logic        fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array;
    logic [15:0] memory_address, fill_addr, fill_data;

    cache_fill_fsm #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid),
        .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .memory_address(memory_address), .write_data_array(write_data_array),
        .write_tag_array(write_tag_array), .fill_addr(fill_addr), .fill_data(fill_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; logic [15:0] d; logic t; } fill_t;
    typedef struct { logic [15:0] a; int due; } pend_t;

    fill_t       exp_q[$];
    logic [15:0] iss_q[$];
    pend_t       pend_q[$];
    bit          busy_m;
    int          cyc, checks, errors, fills, mode, last_due, k;
    logic [15:0] tab [4] = '{16'h1236, 16'hFFF8, 16'h2000, 16'h4000};

    function automatic logic [15:0] mem_f(logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", n, act, exp, cyc);
        end
    endtask

    // Reference model: a fill is 8 sequential words from the 16-byte-aligned base.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            busy_m = 0;
            exp_q.delete();
            iss_q.delete();
        end else if (busy_m) begin
            if (exp_q.size() == 0) busy_m = 0;
        end else if (miss_detected) begin
            for (int i = 0; i < 8; i++) begin
                logic [15:0] a;
                a = (miss_address & 16'hFFF0) + 16'(2 * i);
                exp_q.push_back('{a, mem_f(a), i == 7});
                iss_q.push_back(a);
            end
            busy_m = 1;
            fills++;
        end
    end

    always @(negedge clk) begin
        #1;
        if (cyc >= 1) begin
            chk("fsm_busy", 16'(fsm_busy), 16'(busy_m));
            chk("mem_wr", 16'(mem_wr), 16'd0);
            chk("fill_data_pass", fill_data, memory_data);
            if (iss_q.size() != 0) begin
                chk("mem_enable", 16'(mem_enable), 16'd1);
                chk("memory_address", memory_address, iss_q.pop_front());
            end else begin
                chk("mem_enable_idle", 16'(mem_enable), 16'd0);
                chk("memory_address_idle", memory_address, 16'd0);
            end
            if (memory_data_valid && busy_m && exp_q.size() != 0) begin
                fill_t e;
                e = exp_q.pop_front();
                chk("write_data_array", 16'(write_data_array), 16'd1);
                chk("fill_addr", fill_addr, e.a);
                chk("fill_data", fill_data, e.d);
                chk("write_tag_array", 16'(write_tag_array), 16'(e.t));
            end else begin
                chk("write_data_array_off", 16'(write_data_array), 16'd0);
                chk("write_tag_array_off", 16'(write_tag_array), 16'd0);
                chk("fill_addr_off", fill_addr, 16'd0);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            // Memory: returns words in issue order once their due cycle arrives.
            if (mem_enable) begin
                int due;
                case (mode)
                    0: due = cyc;
                    1: due = cyc + 4;
                    2: due = (last_due + 2 > cyc) ? last_due + 2 : cyc;
                    default: due = cyc + int'($urandom_range(0, 5));
                endcase
                last_due = due;
                pend_q.push_back('{memory_address, due});
            end
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                memory_data_valid = 1;
                memory_data = mem_f(pend_q[0].a);
                void'(pend_q.pop_front());
            end else begin
                memory_data_valid = pend_q.size() == 0 && !busy_m && $urandom_range(0, 3) == 0;
                memory_data = 16'($urandom);
            end
            miss_detected = 0;
            rst = 0;
            if (!busy_m && pend_q.size() == 0 && $urandom_range(0, 1) == 1) begin
                miss_detected = 1;
                miss_address = k < 4 ? tab[k] : 16'($urandom);
                mode = k < 4 ? k : int'($urandom_range(0, 3));
                last_due = -10;
                if (k > 4 && $urandom_range(0, 19) == 0) rst = 1;
                k++;
            end else if (busy_m && $urandom_range(0, 7) == 0) begin
                miss_detected = 1;
                miss_address = $urandom_range(0, 1) ? 16'h4000 : 16'($urandom);
            end
            if (busy_m && k > 4 && $urandom_range(0, 59) == 0) rst = 1;
        end
        chk("fills_started", 16'(fills >= 20), 16'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL provide parameter: ADDR_WIDTH, default 16, byte-address width. Block size is fixed at 16 bytes = 8 x 16-bit words.
REQ-002 SHALL provide port: clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: miss_detected  input  1  cache miss request, sampled in IDLE only.
REQ-005 SHALL provide port: miss_address  input  ADDR_WIDTH  byte address of missing access.
REQ-006 SHALL provide port: memory_data  input  16  read data returned by memory.
REQ-007 SHALL provide port: memory_data_valid  input  1  memory_data valid this cycle; returns in issue order.
REQ-008 SHALL provide port: fsm_busy  output  1  fill in progress.
REQ-009 SHALL provide port: mem_enable  output  1  memory read request this cycle.
REQ-010 SHALL provide port: mem_wr  output  1  memory write strobe; constant 0.
REQ-011 SHALL provide port: memory_address  output  ADDR_WIDTH  word-aligned read address; bit 0 always 0.
REQ-012 SHALL provide port: write_data_array  output  1  one-cycle strobe: write fill_data into the data array.
REQ-013 SHALL provide port: write_tag_array  output  1  one-cycle strobe: write tag/valid for the filled block.
REQ-014 SHALL provide port: fill_addr  output  ADDR_WIDTH  byte address of the word carried on fill_data.
REQ-015 SHALL provide port: fill_data  output  16  equals memory_data (combinational pass-through).

Function
REQ-016 SHALL implement two states: IDLE and FILL.
REQ-017 IDLE -> FILL SHALL occur on a rising edge with miss_detected=1. On that edge, base = {miss_address[ADDR_WIDTH-1:4], 4'b0} is latched and issue_cnt and recv_cnt (4-bit each) are cleared.
REQ-018 fsm_busy SHALL be 1 exactly when state==FILL (registered); it rises the cycle after acceptance.
REQ-019 In FILL with issue_cnt<8: mem_enable=1 and memory_address = base + 2*issue_cnt; issue_cnt increments each cycle. Otherwise mem_enable=0 and memory_address=0.
REQ-020 In FILL, each cycle with memory_data_valid=1: write_data_array=1, fill_addr = base + 2*recv_cnt, and recv_cnt increments.
REQ-021 When memory_data_valid=1 and recv_cnt==7 in FILL: write_tag_array=1 in that same cycle, and the state returns to IDLE on the next edge.
REQ-022 write_data_array, write_tag_array and fill_addr SHALL be 0 whenever the block is not in FILL or memory_data_valid=0.
REQ-023 memory_data_valid in IDLE SHALL be ignored, with no strobes.
REQ-024 miss_detected and miss_address SHALL be ignored while in FILL; base is stable throughout a fill.
REQ-025 Valid data MAY arrive in the same cycle as its issue (zero-latency memory) or any number of cycles later; the block SHALL tolerate gaps between valids.
REQ-026 A new miss SHALL be accepted in the first IDLE cycle after a fill completes (back-to-back fills, one IDLE cycle minimum).
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; offsets never carry beyond bit 3 because base[3:0]=0.

Reset
REQ-028 On rst=1 at a rising edge: state=IDLE, issue_cnt=0, recv_cnt=0, base=0.
REQ-029 After reset, all outputs SHALL be 0 (fsm_busy, mem_enable, mem_wr, memory_address, write_data_array, write_tag_array, fill_addr). fill_data follows memory_data.
REQ-030 rst asserted mid-fill SHALL abort the fill: no further strobes, and late memory_data_valid pulses are ignored.
REQ-031 rst SHALL take priority over miss_detected in the same cycle.

Verification
REQ-032 Zero-latency memory, miss at 0x1236 in cycle 0 -> cycles 1-8: memory_address 0x1230..0x123E; write_data_array each cycle with fill_addr equal to memory_address; write_tag_array in cycle 8; fsm_busy=1 for cycles 1-8; IDLE in cycle 9.
REQ-033 4-cycle memory latency, miss at 0xFFF8 -> addresses 0xFFF0..0xFFFE in cycles 1-8; valids in cycles 5-12; write_tag_array in cycle 12; fsm_busy=0 in cycle 13.
REQ-034 Valid stalls: valids on alternate cycles -> exactly 8 write_data_array pulses, fill_addr increasing by 2, a single write_tag_array on the 8th valid.
REQ-035 Second miss (0x4000) asserted during a fill at 0x2000 -> ignored; base stays 0x2000; re-asserting 0x4000 after completion starts a new fill at 0x4000 in the first IDLE cycle.
REQ-036 rst asserted after the 3rd valid -> next cycle all outputs 0 and state IDLE; the remaining valids produce no strobes.
REQ-037 memory_data_valid pulsed while in IDLE -> no write_data_array or write_tag_array.
